// File: rtl/riscv_alu_issue_pkg.sv
// Shared riscv_defines for the ALU issue slice: ALU op codes, RV32 opcode/funct
// constants and the issue FSM state type.
package riscv_alu_issue_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned RD_W     = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Destination register field of any R/I-type word.
  function automatic logic [RD_W-1:0] inst_rd(input logic [INST_W-1:0] inst);
    return inst[11:7];
  endfunction

endpackage

// File: rtl/riscv_alu_issue_if.sv
// Instruction, ALU and result bus of riscv_alu_issue. The slave modport is the
// issue block; the master modport is its environment (front end, ALU, consumer).
interface riscv_alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  import riscv_alu_issue_pkg::*;

  logic                inst_valid_i;
  logic                inst_ready_o;
  logic [INST_W-1:0]   inst_i;
  logic [XLEN-1:0]     rs1_data_i;
  logic [XLEN-1:0]     rs2_data_i;

  logic [ALU_OP_W-1:0] alu_op_o;
  logic [XLEN-1:0]     alu_a_o;
  logic [XLEN-1:0]     alu_b_o;
  logic [XLEN-1:0]     alu_p_i;

  logic                res_valid_o;
  logic                res_ready_i;
  logic [XLEN-1:0]     res_data_o;
  logic [RD_W-1:0]     res_rd_o;
  logic                illegal_o;

  modport slave (
    input  inst_valid_i, inst_i, rs1_data_i, rs2_data_i, alu_p_i, res_ready_i,
    output inst_ready_o, alu_op_o, alu_a_o, alu_b_o,
    output res_valid_o, res_data_o, res_rd_o, illegal_o
  );

  modport master (
    output inst_valid_i, inst_i, rs1_data_i, rs2_data_i, alu_p_i, res_ready_i,
    input  inst_ready_o, alu_op_o, alu_a_o, alu_b_o,
    input  res_valid_o, res_data_o, res_rd_o, illegal_o
  );

endinterface

// File: rtl/riscv_alu_dec.sv
// Combinational RV32 decode of the supported ALU instructions.
// OP-IMM forms are decoded only when RISCV_ALU_ISSUE_IMM_EN is defined.
module riscv_alu_dec
  import riscv_alu_issue_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output alu_op_e           alu_op,
  output logic              use_imm,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    f3_op;
  logic       f3_ok;
  logic       unused_fields;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign unused_fields = ^{inst_i[24:15], inst_i[11:7]};

  // funct3 mapping shared by the register and immediate forms.
  always_comb begin : f3_map
    f3_op = ALU_ADD;
    f3_ok = 1'b1;
    case (funct3)
      F3_ADD_SUB: f3_op = ALU_ADD;
      F3_SLT:     f3_op = ALU_SLT;
      F3_XOR:     f3_op = ALU_XOR;
      F3_OR:      f3_op = ALU_OR;
      F3_AND:     f3_op = ALU_AND;
      default:    f3_ok = 1'b0;
    endcase
  end

  always_comb begin : decode
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    illegal = 1'b1;
    if (opcode == OPC_OP) begin
      if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
        alu_op  = ALU_SUB;
        illegal = 1'b0;
      end else if (funct7 == F7_BASE && f3_ok) begin
        alu_op  = f3_op;
        illegal = 1'b0;
      end
    end
`ifdef RISCV_ALU_ISSUE_IMM_EN
    else if (opcode == OPC_OP_IMM) begin
      // Upper immediate bits overlap funct7, so 000 is always ADDI.
      use_imm = 1'b1;
      if (f3_ok) begin
        alu_op  = f3_op;
        illegal = 1'b0;
      end
    end
`endif
  end

endmodule

// File: rtl/riscv_alu_issue.sv
// Issue stage for a latency-ALU_LAT external ALU: accepts one RV32 ALU word,
// drives the ALU, captures its result and hands it out on a valid/ready port.
// Define RISCV_ALU_ISSUE_IMM_EN to also accept OP-IMM (ADDI/SLTI/XORI/ORI/ANDI).
module riscv_alu_issue
  import riscv_alu_issue_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rstb,
  riscv_alu_issue_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  state_e          state;
  state_e          state_next;
  logic [CNT_W-1:0] cnt;

  alu_op_e         dec_op;
  logic            dec_use_imm;
  logic            dec_illegal;

  logic            accept;
  logic            accept_legal;
  logic            accept_illegal;
  logic            capture;
  logic            res_take;
  logic [XLEN-1:0] b_next;

  riscv_alu_dec u_dec (
    .inst_i  (bus.inst_i),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .illegal (dec_illegal)
  );

`ifdef RISCV_ALU_ISSUE_IMM_EN
  assign b_next = dec_use_imm ? XLEN'($signed(bus.inst_i[31:20])) : bus.rs2_data_i;
`else
  logic unused_use_imm;
  assign unused_use_imm = dec_use_imm;
  assign b_next = bus.rs2_data_i;
`endif

  assign accept         = bus.inst_valid_i & bus.inst_ready_o;
  assign accept_legal   = accept & ~dec_illegal;
  assign accept_illegal = accept & dec_illegal;

  always_ff @(posedge clk) begin : state_reg
    if (!rstb) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      S_IDLE: if (accept_legal) state_next = S_WAIT;
      S_WAIT: if (cnt == '0) state_next = S_DONE;
      S_DONE: if (bus.res_ready_i) state_next = accept_legal ? S_WAIT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A new word may enter whenever the result slot is empty or being drained.
  always_comb begin : fsm_out
    bus.inst_ready_o = 1'b0;
    capture          = 1'b0;
    res_take         = 1'b0;
    case (state)
      S_IDLE: bus.inst_ready_o = 1'b1;
      S_WAIT: capture = (cnt == '0);
      S_DONE: begin
        bus.inst_ready_o = bus.res_ready_i;
        res_take         = bus.res_ready_i;
      end
      default: ;
    endcase
  end

  // Counts down the ALU pipeline; the result is sampled the cycle after it hits zero.
  always_ff @(posedge clk) begin : lat_cnt
    if (!rstb)                              cnt <= '0;
    else if (accept_legal)                  cnt <= LAT_LOAD;
    else if (state == S_WAIT && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin : issue_regs
    if (!rstb) begin
      bus.alu_op_o  <= '0;
      bus.alu_a_o   <= '0;
      bus.alu_b_o   <= '0;
      bus.res_rd_o  <= '0;
      bus.illegal_o <= 1'b0;
    end else begin
      bus.illegal_o <= accept_illegal;
      if (accept_legal) begin
        bus.alu_op_o <= dec_op;
        bus.alu_a_o  <= bus.rs1_data_i;
        bus.alu_b_o  <= b_next;
        bus.res_rd_o <= inst_rd(bus.inst_i);
      end
    end
  end

  always_ff @(posedge clk) begin : result_regs
    if (!rstb) begin
      bus.res_valid_o <= 1'b0;
      bus.res_data_o  <= '0;
    end else if (capture) begin
      bus.res_valid_o <= 1'b1;
      bus.res_data_o  <= bus.alu_p_i;
    end else if (res_take) begin
      bus.res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Bench for riscv_alu_issue: directed vector table, hand-written corner sequences
// and random words checked against an instruction-level reference model.
module tb_riscv_alu_issue;
  import riscv_alu_issue_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LAT   = 1;
  localparam int          NRAND = 200;

`ifdef RISCV_ALU_ISSUE_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int              hold;
    logic            ill;
    logic [XLEN-1:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic rstb;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  riscv_alu_issue_if #(.XLEN(XLEN)) bus ();

  riscv_alu_issue #(.XLEN(XLEN), .ALU_LAT(LAT)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in ALU with LAT register stages between the operands and alu_p_i.
  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      default: return '0;
    endcase
  endfunction

  logic [XLEN-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_p_i = alu_pipe[LAT-1];

  // Instruction-level reference: legality and architectural result of one word.
  function automatic logic ref_exec(input logic [31:0] inst, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, output logic [XLEN-1:0] res);
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] opb;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    opb = b;
    res = '0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'b0100000) begin
        if (f3 != 3'b000) return 1'b0;
        res = a - b;
        return 1'b1;
      end
      if (f7 != 7'b0000000) return 1'b0;
    end
`ifdef RISCV_ALU_ISSUE_IMM_EN
    else if (opc == 7'b0010011) opb = XLEN'($signed(inst[31:20]));
`endif
    else return 1'b0;
    case (f3)
      3'b000:  res = a + opb;
      3'b010:  res = ($signed(a) < $signed(opb)) ? XLEN'(1) : '0;
      3'b100:  res = a ^ opb;
      3'b110:  res = a | opb;
      3'b111:  res = a & opb;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles the consumer stalls once the result is up.
  task automatic do_txn(input string tag, input logic [31:0] inst, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold, input logic exp_ill,
                        input logic [XLEN-1:0] exp_res);
    int cyc;
    bus.inst_i       = inst;
    bus.rs1_data_i   = a;
    bus.rs2_data_i   = b;
    bus.inst_valid_i = 1'b1;
    bus.res_ready_i  = (hold == 0);
    cyc = 0;
    while (!bus.inst_ready_o && cyc < 20) begin
      tick();
      cyc++;
    end
    chk1($sformatf("%s_ready", tag), bus.inst_ready_o, 1'b1);
    tick();
    bus.inst_valid_i = 1'b0;
    chk1($sformatf("%s_illegal", tag), bus.illegal_o, exp_ill);
    chk1($sformatf("%s_valid_early", tag), bus.res_valid_o, 1'b0);
    if (exp_ill) begin
      chk1($sformatf("%s_ready_after_ill", tag), bus.inst_ready_o, 1'b1);
      tick();
      chk1($sformatf("%s_ill_pulse_end", tag), bus.illegal_o, 1'b0);
      chk1($sformatf("%s_no_result", tag), bus.res_valid_o, 1'b0);
    end else begin
      chk32($sformatf("%s_alu_a", tag), bus.alu_a_o, a);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!bus.res_valid_o && cyc < 20);
      chk32($sformatf("%s_latency", tag), 32'(cyc), 32'(LAT + 1));
      chk32($sformatf("%s_data", tag), bus.res_data_o, exp_res);
      chk32($sformatf("%s_rd", tag), 32'(bus.res_rd_o), 32'(inst[11:7]));
      for (int i = 0; i < hold; i++) begin
        tick();
        chk1($sformatf("%s_hold_valid", tag), bus.res_valid_o, 1'b1);
        chk32($sformatf("%s_hold_data", tag), bus.res_data_o, exp_res);
        chk1($sformatf("%s_hold_ready", tag), bus.inst_ready_o, 1'b0);
      end
      bus.res_ready_i = 1'b1;
      tick();
      chk1($sformatf("%s_valid_drop", tag), bus.res_valid_o, 1'b0);
    end
  endtask

  task automatic wait_result(input string tag, input logic [XLEN-1:0] exp_res,
                             input logic [4:0] exp_rd);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.res_valid_o && cyc < 20);
    chk32($sformatf("%s_latency", tag), 32'(cyc), 32'(LAT + 1));
    chk32($sformatf("%s_data", tag), bus.res_data_o, exp_res);
    chk32($sformatf("%s_rd", tag), 32'(bus.res_rd_o), 32'(exp_rd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb             = 1'b0;
    bus.inst_valid_i = 1'b0;
    bus.inst_i       = '0;
    bus.rs1_data_i   = '0;
    bus.rs2_data_i   = '0;
    bus.res_ready_i  = 1'b0;

    // Reset values, then ready in the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_valid", bus.res_valid_o, 1'b0);
    chk1("rst_illegal", bus.illegal_o, 1'b0);
    chk32("rst_data", bus.res_data_o, '0);
    chk32("rst_rd", 32'(bus.res_rd_o), '0);
    chk32("rst_alu_a", bus.alu_a_o, '0);
    chk32("rst_alu_b", bus.alu_b_o, '0);
    chk32("rst_alu_op", 32'(bus.alu_op_o), '0);
    rstb = 1'b1;
    chk1("rst_release_ready", bus.inst_ready_o, 1'b1);

    vecs.push_back('{r_type(7'h00, 3'b000, 5'd5),  32'd2020, 32'd2021, 0, 1'b0, 32'd4041});
    vecs.push_back('{r_type(7'h20, 3'b000, 5'd6),  32'd2020, 32'd2021, 0, 1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{r_type(7'h00, 3'b010, 5'd7),  32'd0,    32'd0,    0, 1'b0, 32'd0});
    vecs.push_back('{r_type(7'h00, 3'b111, 5'd8),  32'd2020, 32'd2021, 5, 1'b0, 32'd2020});
    vecs.push_back('{r_type(7'h00, 3'b110, 5'd9),  32'd2020, 32'd2021, 0, 1'b0, 32'd2021});
    vecs.push_back('{r_type(7'h00, 3'b100, 5'd10), 32'd2020, 32'd2021, 2, 1'b0, 32'd1});
    vecs.push_back('{r_type(7'h00, 3'b010, 5'd11), 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'd1});
    vecs.push_back('{r_type(7'h00, 3'b000, 5'd0),  32'd1,    32'd2,    0, 1'b0, 32'd3});
    vecs.push_back('{r_type(7'h00, 3'b001, 5'd12), 32'd1,    32'd2,    0, 1'b1, 32'd0});
    vecs.push_back('{r_type(7'h20, 3'b111, 5'd13), 32'd1,    32'd2,    0, 1'b1, 32'd0});
    vecs.push_back('{32'h0000_a083,                32'd1,    32'd2,    0, 1'b1, 32'd0});
    vecs.push_back('{i_type(12'hFFF, 3'b000, 5'd14), 32'd5,  32'd99,   0, !IMM, 32'd4});
    vecs.push_back('{i_type(12'h0F0, 3'b111, 5'd15), 32'h1FF, 32'd0,   1, !IMM, 32'hF0});
    vecs.push_back('{i_type(12'hFFF, 3'b010, 5'd16), 32'd0,  32'd7,    0, !IMM, 32'd0});

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].hold,
             vecs[i].ill, vecs[i].res);

    // Illegal SLL, then a legal ADD accepted on the very next edge.
    bus.res_ready_i  = 1'b1;
    bus.inst_i       = r_type(7'h00, 3'b001, 5'd3);
    bus.rs1_data_i   = 32'd11;
    bus.rs2_data_i   = 32'd22;
    bus.inst_valid_i = 1'b1;
    tick();
    chk1("sll_illegal", bus.illegal_o, 1'b1);
    chk1("sll_no_valid", bus.res_valid_o, 1'b0);
    chk1("sll_ready", bus.inst_ready_o, 1'b1);
    bus.inst_i     = r_type(7'h00, 3'b000, 5'd9);
    bus.rs1_data_i = 32'd7;
    bus.rs2_data_i = 32'd8;
    tick();
    bus.inst_valid_i = 1'b0;
    chk1("sll_pulse_end", bus.illegal_o, 1'b0);
    chk32("sll_next_accepted", bus.alu_a_o, 32'd7);
    wait_result("after_sll", 32'd15, 5'd9);
    tick();
    chk1("after_sll_drop", bus.res_valid_o, 1'b0);

    // Back-to-back ADD then XOR: second accept on the result handshake edge.
    bus.inst_i       = r_type(7'h00, 3'b000, 5'd3);
    bus.rs1_data_i   = 32'd100;
    bus.rs2_data_i   = 32'd23;
    bus.inst_valid_i = 1'b1;
    tick();
    bus.inst_i     = r_type(7'h00, 3'b100, 5'd4);
    bus.rs1_data_i = 32'hF0;
    bus.rs2_data_i = 32'hFF;
    chk1("b2b_wait_not_ready", bus.inst_ready_o, 1'b0);
    wait_result("b2b_add", 32'd123, 5'd3);
    chk1("b2b_no_bubble", bus.inst_ready_o, 1'b1);
    tick();
    bus.inst_valid_i = 1'b0;
    chk1("b2b_valid_drop", bus.res_valid_o, 1'b0);
    chk32("b2b_alu_op", 32'(bus.alu_op_o), 32'(ALU_XOR));
    chk32("b2b_alu_a", bus.alu_a_o, 32'hF0);
    wait_result("b2b_xor", 32'h0F, 5'd4);
    tick();
    chk1("b2b_xor_drop", bus.res_valid_o, 1'b0);

    // Reset while waiting on the ALU drops the in-flight result.
    bus.inst_i       = r_type(7'h00, 3'b000, 5'd21);
    bus.rs1_data_i   = 32'd10;
    bus.rs2_data_i   = 32'd20;
    bus.inst_valid_i = 1'b1;
    tick();
    bus.inst_valid_i = 1'b0;
    rstb             = 1'b0;
    tick();
    chk1("wrst_valid", bus.res_valid_o, 1'b0);
    chk1("wrst_illegal", bus.illegal_o, 1'b0);
    chk32("wrst_data", bus.res_data_o, '0);
    chk32("wrst_rd", 32'(bus.res_rd_o), '0);
    chk32("wrst_alu_a", bus.alu_a_o, '0);
    chk32("wrst_alu_b", bus.alu_b_o, '0);
    chk32("wrst_alu_op", 32'(bus.alu_op_o), '0);
    rstb = 1'b1;
    chk1("wrst_ready", bus.inst_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("wrst_no_result", bus.res_valid_o, 1'b0);
    end

    // Random words against the reference model.
    for (int n = 0; n < NRAND; n++) begin
      logic [31:0]     inst;
      logic [6:0]      opc;
      logic [6:0]      f7;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] r;
      logic            ok;
      case ($urandom_range(0, 3))
        0, 1:    opc = 7'b0110011;
        2:       opc = 7'b0010011;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      inst = {f7, 5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)), 5'($urandom), opc};
      a    = XLEN'($urandom);
      b    = XLEN'($urandom);
      ok   = ref_exec(inst, a, b, r);
      do_txn($sformatf("rnd%0d", n), inst, a, b, int'($urandom_range(0, 2)), !ok, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_alu_issue.md
RISCV_ALU_ISSUE -- requirements
Module: riscv_alu_issue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width.
REQ-002 The block SHALL have parameter ALU_LAT, default 1, range 1..7: ALU register stages between operands and alu_p_i.
REQ-003 The block SHALL have port clk  in  1: sole clock, rising edge.
REQ-004 The block SHALL have port rstb  in  1: reset, synchronous and active-low.
REQ-005 The block SHALL have ports inst_valid_i in 1 and inst_ready_o out 1: instruction handshake.
REQ-006 The block SHALL have port inst_i  in  32: RV32 instruction word.
REQ-007 The block SHALL have ports rs1_data_i and rs2_data_i  in  XLEN: register operands, sampled with inst_i.
REQ-008 The block SHALL have port alu_op_o  out  4: ALU operation code.
REQ-009 The block SHALL have ports alu_a_o and alu_b_o  out  XLEN: ALU operands.
REQ-010 The block SHALL have port alu_p_i  in  XLEN: ALU result.
REQ-011 The block SHALL have ports res_valid_o out 1 and res_ready_i in 1: result handshake.
REQ-012 The block SHALL have ports res_data_o out XLEN and res_rd_o out 5: result value and destination register.
REQ-013 The block SHALL have port illegal_o  out  1: one-cycle pulse when an unsupported instruction is consumed.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 The instruction handshake SHALL fire when inst_valid_i and inst_ready_o are both high at a rising edge E0.
REQ-016 inst_ready_o SHALL be high in IDLE, and in DONE when res_ready_i is high; it SHALL be low otherwise.
REQ-017 At a legal accept, alu_op_o, alu_a_o=rs1_data_i, alu_b_o, res_rd_o=inst_i[11:7] SHALL be registered, and the FSM SHALL go to WAIT.
REQ-018 alu_a_o, alu_b_o and alu_op_o SHALL hold stable until the next accept.
REQ-019 Decode for opcode 0110011 (OP): funct3 000 with funct7 0000000 -> ADD, funct3 000 with funct7 0100000 -> SUB, 111 -> AND, 110 -> OR, 100 -> XOR, 010 -> SLT; alu_b_o=rs2_data_i.
REQ-020 Any other opcode/funct3/funct7 combination SHALL be illegal: illegal_o pulses for the cycle after E0, the word is consumed, no result is produced, and the FSM stays in IDLE.
REQ-021 A 3-bit latency counter SHALL load ALU_LAT on accept and decrement once per cycle in WAIT.
REQ-022 alu_p_i SHALL be captured into res_data_o at edge E0+ALU_LAT+1; res_valid_o SHALL rise at that edge and the FSM SHALL enter DONE.
REQ-023 In DONE, res_valid_o and res_data_o SHALL hold until res_ready_i is high at an edge.
REQ-024 On that edge, the FSM SHALL go to WAIT if a new instruction is simultaneously accepted, else to IDLE; res_valid_o SHALL drop unless a new result is captured at the same edge.
REQ-025 rd=0 SHALL still produce a result; discarding it is the consumer's responsibility.
REQ-026 Arithmetic SHALL be performed by the ALU only; this block SHALL NOT modify alu_p_i.

Reset
REQ-027 While rstb is low at a rising edge, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-028 Reset SHALL drive res_valid_o, illegal_o, res_data_o, res_rd_o, alu_a_o, alu_b_o and alu_op_o to 0.
REQ-029 Reset during WAIT or DONE SHALL abandon the in-flight result silently.
REQ-030 inst_ready_o SHALL be high in the first cycle after reset is released.

Configuration
REQ-031 Macro RISCV_ALU_ISSUE_IMM_EN defined: opcode 0010011 (OP-IMM) is legal with the funct3 mapping of REQ-019.
REQ-032 Under that macro, funct3 000 SHALL always map to ADD, with alu_b_o = inst_i[31:20] sign-extended to XLEN.
REQ-033 Macro RISCV_ALU_ISSUE_IMM_EN undefined: opcode 0010011 SHALL be illegal per REQ-020, and no immediate logic is compiled.

Structure
REQ-034 ALU op codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT) SHALL come from the shared riscv_defines header.
REQ-035 Opcode and funct3/funct7 constants SHALL be added to the shared riscv_defines header.
REQ-036 Decode SHALL live in one combinational sub-module, riscv_alu_dec: inst_i in; alu_op, use_imm, illegal out.
REQ-037 The FSM, counter and registers SHALL be in riscv_alu_issue.

Verification
REQ-038 Reset then OP ADD, rs1=2020, rs2=2021, ALU_LAT=1, res_ready_i=1 -> res_data_o=4041, res_valid_o high exactly at E0+2, res_rd_o=inst[11:7].
REQ-039 OP SUB, rs1=2020, rs2=2021 -> res_data_o=32'hFFFFFFFF; SLT with rs1=0, rs2=0 -> 0.
REQ-040 AND/OR/XOR with 2020/2021 -> 2020, 2021, 1; hold res_ready_i low 5 cycles -> res_valid_o/res_data_o stable and inst_ready_o low.
REQ-041 OP funct3 001 (SLL) -> illegal_o one-cycle pulse, no res_valid_o, next instruction accepted the following cycle.
REQ-042 Back-to-back ADD then XOR with res_ready_i=1 -> second accept on the result-handshake edge, no bubble in inst_ready_o.
REQ-043 rstb low during WAIT -> all outputs 0 at next edge, no res_valid_o; with IMM_EN, ADDI imm=-1, rs1=5 -> 4.
